lane_serializer: RTL and testbench

//   Accepts a 4-lane word (4 x WIDTH bits) with a lane-enable mask over a

---
 rtl/lane_serializer.sv | 112 +++++++++++
 tb/tb_lane_serializer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_serializer.sv
// lane_serializer: captures a 4-lane word plus lane-enable mask and emits the
// enabled lanes one per beat, lowest lane first. out_sel drives the downstream
// mux4 select path and out_data is the stored lane picked by that select.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The producer holds valid and its payload until that edge. A ready value
// never depends on the valid of the same interface. out_data/out_sel/out_last
// stay stable while out_valid=1 and out_ready=0.
module lane_serializer #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*WIDTH-1:0] in_data,
    input  logic [3:0]         in_mask,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         out_sel,
    output logic               out_last,
    output logic               busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] lane [4];
    logic [3:0]       mask;
    logic [1:0]       sel;

    logic [3:0] above;      // lane positions strictly above sel
    logic [3:0] higher;     // enabled lanes still to be emitted after this beat
    logic [1:0] next_sel;
    logic       beat_acc;
    logic       capture;

    // Index of the lowest set bit; callers guarantee at least one bit is set.
    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        if (m[0])      lowest_set = 2'd0;
        else if (m[1]) lowest_set = 2'd1;
        else if (m[2]) lowest_set = 2'd2;
        else           lowest_set = 2'd3;
    endfunction

    // Mask of lane positions above the current select.
    always_comb begin
        above = 4'b0000;
        case (sel)
            2'd0:    above = 4'b1110;
            2'd1:    above = 4'b1100;
            2'd2:    above = 4'b1000;
            default: above = 4'b0000;
        endcase
    end

    assign higher    = mask & above;
    assign next_sel  = lowest_set(higher);
    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out_sel   = sel;
    assign out_last  = (state == SEND) && (higher == 4'b0000);
    assign beat_acc  = out_valid && out_ready;
    // Ready while idle, or when the final beat leaves this cycle (back-to-back).
    assign in_ready  = (state == IDLE) || (beat_acc && out_last);
    assign capture   = in_valid && in_ready;

    // Per-bit mux4 of the stored lanes under the current select.
    always_comb begin
        out_data = '0;
        case (sel)
            2'd0:    out_data = lane[0];
            2'd1:    out_data = lane[1];
            2'd2:    out_data = lane[2];
            default: out_data = lane[3];
        endcase
    end

    // Lane storage: loaded only on capture, untouched while beats go out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) lane[i] <= '0;
        end else if (capture) begin
            for (int i = 0; i < 4; i++) lane[i] <= in_data[i*WIDTH +: WIDTH];
        end
    end

    // Control FSM: capture starts a word (or drops an empty one), accepted
    // beats walk sel upward through the enabled lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mask  <= 4'b0000;
            sel   <= 2'd0;
        end else if (capture) begin
            mask <= in_mask;
            if (in_mask != 4'b0000) begin
                state <= SEND;
                sel   <= lowest_set(in_mask);
            end else begin
                state <= IDLE;
                sel   <= 2'd0;
            end
        end else if (beat_acc) begin
            if (out_last) state <= IDLE;
            else          sel   <= next_sel;
        end
    end

endmodule

// File: tb/tb_lane_serializer.sv
// tb_lane_serializer: directed stimulus for lane_serializer with a queue-based
// beat model checked every cycle, plus literal expectations per scenario.
module tb_lane_serializer;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_mask;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_last;
  logic           busy;

  lane_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  // Expected beats, oldest first: {last, sel, data}
  logic [W+2:0] exp_q[$];

  // Beats actually accepted from the DUT
  logic [W-1:0] acc_data[$];
  logic [1:0]   acc_sel[$];
  logic         acc_last[$];
  int           acc_cyc[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // A captured word becomes one beat per enabled lane, ascending; the highest
  // enabled lane carries last.
  task automatic model_push(input logic [4*W-1:0] d, input logic [3:0] m);
    int hi;
    hi = -1;
    for (int i = 0; i < 4; i++) if (m[i]) hi = i;
    for (int i = 0; i < 4; i++)
      if (m[i]) exp_q.push_back({(i == hi), 2'(i), d[i*W +: W]});
  endtask

  task automatic clear_log();
    acc_data.delete();
    acc_sel.delete();
    acc_last.delete();
    acc_cyc.delete();
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin : cmp
    logic exp_v;
    logic exp_rdy;
    if (!rst_n) begin
      exp_q.delete();
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_sel", out_sel, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
    end else begin
      exp_v   = (exp_q.size() != 0);
      exp_rdy = !exp_v || (exp_q.size() == 1 && out_ready);
      check("out_valid", out_valid, exp_v);
      check("busy", busy, exp_v);
      check("in_ready", in_ready, exp_rdy);
      if (exp_v) begin
        check("out_data", out_data, exp_q[0][W-1:0]);
        check("out_sel", out_sel, exp_q[0][W+1:W]);
        check("out_last", out_last, exp_q[0][W+2]);
      end
      if (out_valid && out_ready) begin
        acc_data.push_back(out_data);
        acc_sel.push_back(out_sel);
        acc_last.push_back(out_last);
        acc_cyc.push_back(cyc);
      end
      if (exp_v && out_ready) void'(exp_q.pop_front());
      if (in_valid && exp_rdy) model_push(in_data, in_mask);
    end
  end

  // ---------------- drivers ----------------
  // Offer a word and hold it until captured; afterwards scramble the inputs,
  // which must be ignored while not captured.
  task automatic send_word(input logic [4*W-1:0] d, input logic [3:0] m);
    int t;
    in_data  = d;
    in_mask  = m;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) fail_now("send_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_mask  = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) fail_now("idle_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string name, input int idx, input logic [W-1:0] d,
                            input logic [1:0] s, input logic l);
    if (idx < acc_data.size()) begin
      check({name, "_data"}, acc_data[idx], d);
      check({name, "_sel"}, acc_sel[idx], s);
      check({name, "_last"}, acc_last[idx], l);
    end else begin
      fail_now({name, "_missing"});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mask   = 4'b0000;
    out_ready = 1'b1;

    // 1: reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t1_in_ready", in_ready, 1);
    check("t1_out_valid", out_valid, 0);
    check("t1_busy", busy, 0);
    check("t1_out_sel", out_sel, 0);

    // 2: full mask, beats 1..4 on consecutive cycles
    clear_log();
    send_word({32'd4, 32'd3, 32'd2, 32'd1}, 4'b1111);
    wait_idle();
    check("t2_count", acc_data.size(), 4);
    check_beat("t2_b0", 0, 32'd1, 2'd0, 1'b0);
    check_beat("t2_b1", 1, 32'd2, 2'd1, 1'b0);
    check_beat("t2_b2", 2, 32'd3, 2'd2, 1'b0);
    check_beat("t2_b3", 3, 32'd4, 2'd3, 1'b1);
    if (acc_cyc.size() == 4) check("t2_span", acc_cyc[3] - acc_cyc[0], 3);

    // 3: sparse mask under backpressure
    clear_log();
    out_ready = 1'b0;
    send_word({32'd44, 32'd33, 32'd22, 32'd11}, 4'b1010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_data", out_data, 32'd22);
      check("t3_hold_sel", out_sel, 2'd1);
      check("t3_hold_last", out_last, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();
    check("t3_count", acc_data.size(), 2);
    check_beat("t3_b0", 0, 32'd22, 2'd1, 1'b0);
    check_beat("t3_b1", 1, 32'd44, 2'd3, 1'b1);

    // 4: empty mask dropped, then a single-lane word
    clear_log();
    send_word({32'd8, 32'd7, 32'd6, 32'd5}, 4'b0000);
    repeat (3) begin
      @(negedge clk);
      check("t4_no_valid", out_valid, 0);
      check("t4_ready", in_ready, 1);
    end
    @(posedge clk);
    #1;
    check("t4_no_beats", acc_data.size(), 0);
    send_word({32'd0, 32'd0, 32'd0, 32'd55}, 4'b0001);
    wait_idle();
    check("t4_count", acc_data.size(), 1);
    check_beat("t4_b0", 0, 32'd55, 2'd0, 1'b1);

    // 5: back-to-back words with no bubble
    clear_log();
    send_word({32'd0, 32'd7, 32'd0, 32'd0}, 4'b0100);
    send_word({32'd0, 32'd0, 32'd0, 32'd9}, 4'b0001);
    wait_idle();
    check("t5_count", acc_data.size(), 2);
    check_beat("t5_b0", 0, 32'd7, 2'd2, 1'b1);
    check_beat("t5_b1", 1, 32'd9, 2'd0, 1'b1);
    if (acc_cyc.size() == 2) check("t5_gap", acc_cyc[1] - acc_cyc[0], 1);

    // 6: asynchronous reset after the first beat
    clear_log();
    send_word({32'hA4, 32'hA3, 32'hA2, 32'hA1}, 4'b1111);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_in_ready", in_ready, 1);
    check("t6_sel", out_sel, 0);
    check("t6_data", out_data, 0);
    check("t6_last", out_last, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t6_count", acc_data.size(), 1);
    check_beat("t6_b0", 0, 32'hA1, 2'd0, 1'b0);
    check("t6_idle", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
